// File: rtl/phi_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | phi_pkg: widths, formats and types for the shared phi LUT.        |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
package phi_pkg;

  localparam int PHI_X_W    = 6;
  localparam int PHI_Y_W    = 4;
  localparam int PHI_X_FRAC = 4;
  localparam int PHI_Y_FRAC = 2;

  typedef logic [PHI_X_W-1:0] phi_x_t;
  typedef logic [PHI_Y_W-1:0] phi_y_t;

  localparam phi_y_t PHI_MAX = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/phi_lut.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | phi_lut: phi(x)=log((1+e^-x)/(1-e^-x)), U2.4 in, U2.2 out.        |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module phi_lut
  import phi_pkg::*;
(
  input  phi_x_t x_i,
  output phi_y_t y_o
);

  // phi is monotone decreasing; each bound is the last code that rounds to
  // the given output (round-to-nearest of 4*phi(code/16), saturated at 0).
  always_comb begin
    y_o = '0;
    if      (x_i == 6'd0)  y_o = PHI_MAX;
    else if (x_i <= 6'd1)  y_o = 4'd14;
    else if (x_i <= 6'd2)  y_o = 4'd11;
    else if (x_i <= 6'd3)  y_o = 4'd9;
    else if (x_i <= 6'd4)  y_o = 4'd8;
    else if (x_i <= 6'd6)  y_o = 4'd7;
    else if (x_i <= 6'd8)  y_o = 4'd6;
    else if (x_i <= 6'd10) y_o = 4'd5;
    else if (x_i <= 6'd14) y_o = 4'd4;
    else if (x_i <= 6'd19) y_o = 4'd3;
    else if (x_i <= 6'd26) y_o = 4'd2;
    else if (x_i <= 6'd44) y_o = 4'd1;
    else                   y_o = 4'd0;
  end

endmodule
`default_nettype wire

// File: rtl/phi_lut_arbiter_rr_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | rr_arbiter: round-robin grant, search upward from pointer, wraps. |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    winner_o
);

  logic [ID_W-1:0] ptr_q, ptr_d;

  always_comb begin
    int  idx;
    logic found;
    grant_o  = '0;
    winner_o = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        winner_o     = ID_W'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = (int'(winner_o) == NUM_REQ - 1) ? '0 : winner_o + ID_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule
`default_nettype wire

// File: rtl/phi_lut_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | phi_lut_arbiter: NUM_REQ requesters share one phi LUT through a   |
// | round-robin arbiter and a 2-stage back-pressurable pipeline.      |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module phi_lut_arbiter
  import phi_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int X_W     = PHI_X_W,
  parameter int Y_W     = PHI_Y_W,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [NUM_REQ*X_W-1:0] req_x_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [ID_W-1:0]        rsp_id_o,
  output logic [Y_W-1:0]         rsp_y_o,
  output logic                   busy_o
);

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    winner;
  logic               s1_en, s2_en, advance;

  logic               s1_v_q, s1_v_d;
  logic [X_W-1:0]     s1_x_q, s1_x_d;
  logic [ID_W-1:0]    s1_id_q, s1_id_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [Y_W-1:0]     rsp_y_q, rsp_y_d;
  phi_y_t             lut_y;

  assign s2_en       = !rsp_valid_q || rsp_ready_i;
  assign s1_en       = !s1_v_q || s2_en;
  assign req_ready_o = rst ? '0 : (grant & {NUM_REQ{s1_en}});
  assign advance     = |(req_valid_i & req_ready_o);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_valid_i),
    .advance_i (advance),
    .grant_o   (grant),
    .winner_o  (winner)
  );

  phi_lut u_lut (
    .x_i (s1_x_q),
    .y_o (lut_y)
  );

  always_comb begin
    s1_v_d  = s1_v_q;
    s1_x_d  = s1_x_q;
    s1_id_d = s1_id_q;
    if (s1_en) begin
      s1_v_d  = |grant;
      s1_x_d  = req_x_i[winner*X_W +: X_W];
      s1_id_d = winner;
    end
  end

  // Payload only moves with a valid entry so an idle bus keeps its last value.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_y_d     = rsp_y_q;
    if (s2_en) begin
      rsp_valid_d = s1_v_q;
      if (s1_v_q) begin
        rsp_id_d = s1_id_q;
        rsp_y_d  = lut_y;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q      <= 1'b0;
      s1_x_q      <= '0;
      s1_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_y_q     <= '0;
    end else begin
      s1_v_q      <= s1_v_d;
      s1_x_q      <= s1_x_d;
      s1_id_q     <= s1_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_y_q     <= rsp_y_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_y_o     = rsp_y_q;
  assign busy_o      = s1_v_q || rsp_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_phi_lut_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_phi_lut_arbiter: vectors, directed sequences and random traffic|
// | against a transaction-level model.  Rev 1.0                       |
// +-------------------------------------------------------------------+
module tb_phi_lut_arbiter;

  localparam int N  = 4;
  localparam int XW = 6;
  localparam int YW = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*XW-1:0] req_x;
  logic [N-1:0]    req_ready;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic [YW-1:0]   rsp_y;
  logic            busy;

  always #5 clk = ~clk;

  phi_lut_arbiter #(.NUM_REQ(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_x_i     (req_x),
    .req_ready_o (req_ready),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_id_o    (rsp_id),
    .rsp_y_o     (rsp_y),
    .busy_o      (busy)
  );

  int n_chk = 0;
  int n_err = 0;

  typedef struct { int x; int y; } vec_t;
  typedef struct { int id; int y; } rsp_t;
  vec_t vecs[11];
  rsp_t sbq[$];
  int   ey[4];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference phi straight from the formula: round(4*phi(code/16)), clamp 15.
  function automatic int phi_ref(input int code);
    real x, e, p;
    int  v;
    if (code == 0) return 15;
    x = code / 16.0;
    e = $exp(-x);
    p = $ln((1.0 + e) / (1.0 - e));
    v = $rtoi(p * 4.0 + 0.5);
    if (v > 15) v = 15;
    return v;
  endfunction

  task automatic set_x(input int i, input int v);
    req_x[i*XW +: XW] = XW'(v);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic send_one(input int id, input int x, input int exp_y, input string nm);
    bit ok;
    req_valid     = '0;
    req_valid[id] = 1'b1;
    set_x(id, x);
    rsp_ready = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 8 && !ok; c++) begin
      @(negedge clk);
      if (req_ready[id]) ok = 1'b1;
      else cyc();
    end
    chk({nm, "_acc"}, int'(ok), 1);
    cyc();
    req_valid = '0;
    ok = 1'b0;
    for (int c = 0; c < 8 && !ok; c++) begin
      @(negedge clk);
      if (rsp_valid) ok = 1'b1;
      else cyc();
    end
    chk({nm, "_rsp"}, int'(ok), 1);
    if (ok) begin
      chk({nm, "_id"}, int'(rsp_id), id);
      chk({nm, "_y"}, int'(rsp_y), exp_y);
    end
    cyc();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int   ptr_m, inflight, sid, sy;
    bit   stall;
    logic [N-1:0] acc;

    vecs[0]  = '{0, 15};  vecs[1]  = '{1, 14};  vecs[2]  = '{2, 11};
    vecs[3]  = '{4, 8};   vecs[4]  = '{8, 6};   vecs[5]  = '{16, 3};
    vecs[6]  = '{20, 2};  vecs[7]  = '{27, 1};  vecs[8]  = '{44, 1};
    vecs[9]  = '{45, 0};  vecs[10] = '{63, 0};
    ey[0] = 14; ey[1] = 8; ey[2] = 3; ey[3] = 0;

    // Reset state; ready must stay low under reset even with requests pending.
    rst = 1'b1; req_valid = '1; req_x = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", int'(req_ready), 0);
    cyc();
    rst = 1'b0; req_valid = '0;
    @(negedge clk);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_id", int'(rsp_id), 0);
    chk("rst_rsp_y", int'(rsp_y), 0);
    chk("rst_busy", int'(busy), 0);
    cyc();

    // Single request, 2-cycle latency.
    req_valid = 4'b0001; set_x(0, 0);
    @(negedge clk); chk("t1_ready", int'(req_ready), 1);
    cyc(); req_valid = '0;
    @(negedge clk); chk("t1_rv_early", int'(rsp_valid), 0); chk("t1_busy", int'(busy), 1);
    cyc();
    @(negedge clk);
    chk("t1_rv", int'(rsp_valid), 1); chk("t1_id", int'(rsp_id), 0); chk("t1_y", int'(rsp_y), 15);
    cyc();
    @(negedge clk); chk("t1_idle_busy", int'(busy), 0); chk("t1_idle_rv", int'(rsp_valid), 0);
    cyc();

    // All four at once.
    do_reset();
    req_valid = 4'hF; set_x(0, 1); set_x(1, 4); set_x(2, 16); set_x(3, 45);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c < 4) chk("t2_grant", int'(req_ready), 1 << c);
      else       chk("t2_ready_idle", int'(req_ready), 0);
      if (c >= 2) begin
        chk("t2_rv", int'(rsp_valid), 1);
        chk("t2_id", int'(rsp_id), c - 2);
        chk("t2_y", int'(rsp_y), ey[c-2]);
      end else begin
        chk("t2_rv_early", int'(rsp_valid), 0);
      end
      cyc();
      if (c < 4) req_valid[c] = 1'b0;
    end

    // Two continuous requesters alternate.
    req_valid = 4'b1010; set_x(1, 5); set_x(3, 9);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("t3_grant", int'(req_ready), (c % 2 == 0) ? 2 : 8);
      cyc();
    end
    req_valid = '0;
    repeat (3) cyc();

    // Back-pressure with two buffered entries plus a third waiting.
    req_valid = 4'b0100; set_x(2, 27); rsp_ready = 1'b1;
    @(negedge clk); chk("t4_acc0", int'(req_ready), 4);
    cyc(); set_x(2, 44); rsp_ready = 1'b0;
    @(negedge clk); chk("t4_acc1", int'(req_ready), 4);
    cyc(); set_x(2, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t4_hold_rv", int'(rsp_valid), 1);
      chk("t4_hold_id", int'(rsp_id), 2);
      chk("t4_hold_y", int'(rsp_y), 1);
      chk("t4_full_ready", int'(req_ready), 0);
      chk("t4_busy", int'(busy), 1);
      cyc();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t4_rA_v", int'(rsp_valid), 1); chk("t4_rA_y", int'(rsp_y), 1);
    chk("t4_acc2", int'(req_ready), 4);
    cyc(); req_valid = '0;
    @(negedge clk);
    chk("t4_rB_v", int'(rsp_valid), 1); chk("t4_rB_id", int'(rsp_id), 2); chk("t4_rB_y", int'(rsp_y), 1);
    cyc();
    @(negedge clk); chk("t4_rC_v", int'(rsp_valid), 1); chk("t4_rC_y", int'(rsp_y), 15);
    cyc();
    @(negedge clk); chk("t4_done_rv", int'(rsp_valid), 0); chk("t4_done_busy", int'(busy), 0);
    cyc();

    // Reset with two entries in flight; pointer is at 3 here.
    req_valid = 4'b0011; set_x(0, 8); set_x(1, 16); rsp_ready = 1'b0;
    @(negedge clk); chk("t5_acc0", int'(req_ready), 1);
    cyc(); req_valid = 4'b0010;
    @(negedge clk); chk("t5_acc1", int'(req_ready), 2);
    cyc(); req_valid = '0;
    @(negedge clk); chk("t5_full_busy", int'(busy), 1); chk("t5_full_rv", int'(rsp_valid), 1);
    cyc(); rst = 1'b1;
    cyc();
    @(negedge clk); chk("t5_rst_rv", int'(rsp_valid), 0); chk("t5_rst_busy", int'(busy), 0);
    cyc(); rst = 1'b0; rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); chk("t5_no_stale", int'(rsp_valid), 0);
      cyc();
    end
    req_valid = 4'b1010;
    @(negedge clk); chk("t5_ptr0_grant", int'(req_ready), 2);
    cyc(); req_valid = '0;
    repeat (3) cyc();

    // LUT reference points, then every code against the formula.
    for (int i = 0; i < 11; i++)
      send_one(0, vecs[i].x, vecs[i].y, $sformatf("vec%0d", vecs[i].x));
    for (int x = 0; x < 64; x++)
      send_one(0, x, phi_ref(x), $sformatf("sweep%0d", x));

    // Random traffic against a capacity-2 in-order model.
    do_reset();
    ptr_m = 0; inflight = 0; stall = 1'b0; sid = 0; sy = 0; rsp_ready = 1'b1;
    for (int cy = 0; cy < 600; cy++) begin
      int w;
      logic [N-1:0] er;
      @(negedge clk);
      er = '0; w = -1;
      if (inflight < 2 || rsp_ready)
        for (int k = 0; k < N; k++)
          if (w < 0 && req_valid[(ptr_m + k) % N]) w = (ptr_m + k) % N;
      if (w >= 0) er[w] = 1'b1;
      chk("rnd_ready", int'(req_ready), int'(er));
      chk("rnd_busy", int'(busy), int'(inflight > 0));
      if (stall) begin
        chk("rnd_stable_v", int'(rsp_valid), 1);
        chk("rnd_stable_id", int'(rsp_id), sid);
        chk("rnd_stable_y", int'(rsp_y), sy);
      end
      if (rsp_valid && rsp_ready) begin
        if (sbq.size() == 0) begin
          chk("rnd_spurious", 1, 0);
        end else begin
          rsp_t e;
          e = sbq.pop_front();
          chk("rnd_id", int'(rsp_id), e.id);
          chk("rnd_y", int'(rsp_y), e.y);
        end
        inflight--;
      end
      stall = rsp_valid && !rsp_ready;
      sid = int'(rsp_id); sy = int'(rsp_y);
      acc = req_valid & req_ready;
      if (w >= 0) begin
        sbq.push_back('{w, phi_ref(int'(req_x[w*XW +: XW]))});
        ptr_m = (w + 1) % N;
        inflight++;
      end
      cyc();
      for (int i = 0; i < N; i++) begin
        if (acc[i] || !req_valid[i]) begin
          req_valid[i] = (cy < 588) && ($urandom_range(0, 2) != 0);
          set_x(i, int'($urandom_range(0, 63)));
        end
      end
      rsp_ready = (cy >= 588) || ($urandom_range(0, 3) != 0);
    end
    chk("rnd_drained", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
